// File: rtl/hilo_div_sequencer.sv
// hilo_div_sequencer
//   Front end of the multi-cycle 32-bit divider. It owns the HI/LO registers,
//   decodes DIV/DIVU/MFHI/MFLO/MTHI/MTLO from EX, hands operand magnitudes to an
//   unsigned divider core, applies the sign fix-up on the result, and stalls the
//   pipeline while a division is outstanding.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-low reset
//   op_valid  op_funct/op_a/op_b valid this cycle
//   op_funct  DIV=26 DIVU=27 MFHI=16 MTHI=17 MFLO=18 MTLO=19 (others ignored)
//   op_a      dividend / MTHI-MTLO source
//   op_b      divisor
//   stall     recognised op presented while not IDLE (combinational)
//   busy      sequencer not IDLE
//   dv_start  one-cycle launch pulse to the core
//   dv_a      dividend magnitude to core, held through the operation
//   dv_b      divisor magnitude to core, held through the operation
//   dv_done   core result valid pulse
//   dv_quot   unsigned quotient from core
//   dv_rem    unsigned remainder from core
//   hi, lo    HI/LO architectural registers
//   mf_data   MFHI/MFLO read data (combinational)
//   mf_valid  mf_data valid this cycle
//   err       one-cycle pulse when a division is aborted on timeout
module hilo_div_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [5:0]  op_funct,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        stall,
    output logic        busy,
    output logic        dv_start,
    output logic [31:0] dv_a,
    output logic [31:0] dv_b,
    input  logic        dv_done,
    input  logic [31:0] dv_quot,
    input  logic [31:0] dv_rem,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data,
    output logic        mf_valid,
    output logic        err
);

    localparam logic [5:0] F_MFHI = 6'd16;
    localparam logic [5:0] F_MTHI = 6'd17;
    localparam logic [5:0] F_MFLO = 6'd18;
    localparam logic [5:0] F_MTLO = 6'd19;
    localparam logic [5:0] F_DIV  = 6'd26;
    localparam logic [5:0] F_DIVU = 6'd27;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_INC  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    // Two's complement negate, wrapping (so -0x80000000 stays 0x80000000).
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of a signed 32-bit value as an unsigned number.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        logic [31:0] m;
        if (v[31]) begin
            m = neg32(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    logic [1:0]    state_r;
    logic [CW-1:0] counter_r;
    logic [31:0]   hi_r;
    logic [31:0]   lo_r;
    logic [31:0]   dv_a_r;
    logic [31:0]   dv_b_r;
    logic          dv_start_r;
    logic          err_r;
    logic          neg_q_r;
    logic          neg_r_r;
    logic          recog_s;
    logic          idle_s;
    logic          accept_s;

    // Decode which funct codes this block owns.
    always_comb begin
        recog_s = 1'b0;
        case (op_funct)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_DIV, F_DIVU: recog_s = op_valid;
            default: recog_s = 1'b0;
        endcase
    end

    assign idle_s   = (state_r == S_IDLE);
    assign accept_s = recog_s && idle_s;
    assign stall    = recog_s && !idle_s;
    assign busy     = !idle_s;
    assign dv_start = dv_start_r;
    assign dv_a     = dv_a_r;
    assign dv_b     = dv_b_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign err      = err_r;

    // Move-from read port; only answers when the op is actually accepted.
    always_comb begin
        mf_data  = 32'd0;
        mf_valid = 1'b0;
        if (accept_s && (op_funct == F_MFHI)) begin
            mf_data  = hi_r;
            mf_valid = 1'b1;
        end else if (accept_s && (op_funct == F_MFLO)) begin
            mf_data  = lo_r;
            mf_valid = 1'b1;
        end else begin
            mf_data  = 32'd0;
            mf_valid = 1'b0;
        end
    end

    // Sequencer FSM, HI/LO update and divider handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            counter_r  <= CNT_ZERO;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            dv_a_r     <= 32'd0;
            dv_b_r     <= 32'd0;
            dv_start_r <= 1'b0;
            err_r      <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
        end else begin
            dv_start_r <= 1'b0;
            err_r      <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        case (op_funct)
                            F_MTHI: hi_r <= op_a;
                            F_MTLO: lo_r <= op_a;
                            F_DIV, F_DIVU: begin
                                if (op_b == 32'd0) begin
                                    // Divide by zero never reaches the core.
                                    hi_r <= op_a;
                                    lo_r <= 32'hFFFF_FFFF;
                                end else begin
                                    if (op_funct == F_DIV) begin
                                        dv_a_r  <= mag32(op_a);
                                        dv_b_r  <= mag32(op_b);
                                        neg_q_r <= op_a[31] ^ op_b[31];
                                        neg_r_r <= op_a[31];
                                    end else begin
                                        dv_a_r  <= op_a;
                                        dv_b_r  <= op_b;
                                        neg_q_r <= 1'b0;
                                        neg_r_r <= 1'b0;
                                    end
                                    // Registered so the pulse coincides with ISSUE.
                                    dv_start_r <= 1'b1;
                                    state_r    <= S_ISSUE;
                                end
                            end
                            default: begin
                                // MFHI/MFLO are served combinationally.
                            end
                        endcase
                    end
                end
                S_ISSUE: begin
                    counter_r <= CNT_ZERO;
                    state_r   <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the last allowed cycle still wins.
                    if (dv_done) begin
                        hi_r    <= neg_r_r ? neg32(dv_rem) : dv_rem;
                        lo_r    <= neg_q_r ? neg32(dv_quot) : dv_quot;
                        state_r <= S_IDLE;
                    end else if (counter_r == CNT_LAST) begin
                        err_r   <= 1'b1;
                        state_r <= S_IDLE;
                    end else begin
                        counter_r <= counter_r + CNT_INC;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_sequencer.sv
module tb_hilo_div_sequencer;

    localparam int TIMEOUT = 64;
    localparam logic [5:0] F_MFHI = 6'd16;
    localparam logic [5:0] F_MTHI = 6'd17;
    localparam logic [5:0] F_MFLO = 6'd18;
    localparam logic [5:0] F_MTLO = 6'd19;
    localparam logic [5:0] F_DIV  = 6'd26;
    localparam logic [5:0] F_DIVU = 6'd27;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [5:0]  op_funct;
    logic [31:0] op_a, op_b;
    logic        stall, busy, dv_start;
    logic [31:0] dv_a, dv_b;
    logic        dv_done;
    logic [31:0] dv_quot, dv_rem;
    logic [31:0] hi, lo, mf_data;
    logic        mf_valid, err;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi, m_lo;

    hilo_div_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_funct(op_funct),
        .op_a(op_a), .op_b(op_b), .stall(stall), .busy(busy), .dv_start(dv_start),
        .dv_a(dv_a), .dv_b(dv_b), .dv_done(dv_done), .dv_quot(dv_quot), .dv_rem(dv_rem),
        .hi(hi), .lo(lo), .mf_data(mf_data), .mf_valid(mf_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Architectural result of a DIV/DIVU using wide signed arithmetic, truncating toward zero.
    function automatic void ref_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            h = a;
            l = 32'hFFFF_FFFF;
        end else begin
            if (f == F_DIV) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q = sa / sb;
            r = sa % sb;
            l = q[31:0];
            h = r[31:0];
        end
    endfunction

    function automatic logic [31:0] ref_mag(input logic [5:0] f, input logic [31:0] v);
        longint s;
        if (f == F_DIV) begin
            s = longint'($signed(v));
            if (s < 0) s = -s;
        end else begin
            s = longint'({32'd0, v});
        end
        return s[31:0];
    endfunction

    task automatic test_reset();
        reset = 1'b0; op_valid = 1'b0; op_funct = 6'd0; op_a = 32'd0; op_b = 32'd0;
        dv_done = 1'b0; dv_quot = 32'd0; dv_rem = 32'd0;
        repeat (2) @(negedge clk);
        vectors++; if ({hi, lo} !== 64'd0) begin miscompares++; $display("FAIL reset_hilo: got %h_%h exp 0", hi, lo); end
        vectors++; if ({dv_a, dv_b} !== 64'd0) begin miscompares++; $display("FAIL reset_dvab: got %h_%h exp 0", dv_a, dv_b); end
        vectors++; if ({dv_start, err, busy, stall} !== 4'b0000) begin miscompares++; $display("FAIL reset_ctl: got %b exp 0000", {dv_start, err, busy, stall}); end
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    // Full division transaction with a core model that answers after 'delay' WAIT cycles.
    task automatic run_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int delay);
        logic [31:0] eh, el, ma, mb;
        ref_div(f, a, b, eh, el);
        ma = ref_mag(f, a);
        mb = ref_mag(f, b);
        @(negedge clk);
        op_valid = 1'b1; op_funct = f; op_a = a; op_b = b;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL div_accept_stall: got %b exp 0", stall); end
        @(negedge clk);
        op_valid = 1'b0;
        if (b == 32'd0) begin
            vectors++; if ({dv_start, busy} !== 2'b00) begin miscompares++; $display("FAIL div0_ctl: got %b exp 00", {dv_start, busy}); end
            vectors++; if ({hi, lo} !== {eh, el}) begin miscompares++; $display("FAIL div0_hilo: got %h_%h exp %h_%h", hi, lo, eh, el); end
        end else begin
            vectors++; if ({dv_start, busy} !== 2'b11) begin miscompares++; $display("FAIL issue_ctl: got %b exp 11", {dv_start, busy}); end
            vectors++; if ({dv_a, dv_b} !== {ma, mb}) begin miscompares++; $display("FAIL issue_operands: got %h_%h exp %h_%h", dv_a, dv_b, ma, mb); end
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                vectors++; if ({dv_start, busy} !== 2'b01) begin miscompares++; $display("FAIL wait_ctl: cycle %0d got %b exp 01", i, {dv_start, busy}); end
            end
            dv_done = 1'b1; dv_quot = ma / mb; dv_rem = ma % mb;
            @(negedge clk);
            dv_done = 1'b0; dv_quot = $urandom; dv_rem = $urandom;
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL done_busy: got %b exp 0", busy); end
            vectors++; if ({hi, lo} !== {eh, el}) begin miscompares++; $display("FAIL div_result: f=%0d a=%h b=%h got %h_%h exp %h_%h", f, a, b, hi, lo, eh, el); end
        end
        m_hi = eh; m_lo = el;
    endtask

    task automatic do_mt(input logic [5:0] f, input logic [31:0] a);
        @(negedge clk);
        op_valid = 1'b1; op_funct = f; op_a = a; op_b = $urandom;
        #1;
        vectors++; if ({stall, mf_valid} !== 2'b00) begin miscompares++; $display("FAIL mt_ctl: got %b exp 00", {stall, mf_valid}); end
        @(negedge clk);
        op_valid = 1'b0;
        if (f == F_MTHI) m_hi = a; else m_lo = a;
        vectors++; if ({hi, lo} !== {m_hi, m_lo}) begin miscompares++; $display("FAIL mt_hilo: got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); end
    endtask

    task automatic do_mf(input logic [5:0] f);
        logic [31:0] exp_d;
        exp_d = (f == F_MFHI) ? m_hi : m_lo;
        @(negedge clk);
        op_valid = 1'b1; op_funct = f; op_a = $urandom; op_b = $urandom;
        #1;
        vectors++; if ({mf_valid, stall, mf_data} !== {2'b10, exp_d}) begin miscompares++; $display("FAIL mf_read: got v=%b s=%b d=%h exp v=1 s=0 d=%h", mf_valid, stall, mf_data, exp_d); end
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic test_spec_cases();
        run_div(F_DIVU, 32'd100, 32'd7, 32);
        vectors++; if ({hi, lo} !== {32'd2, 32'd14}) begin miscompares++; $display("FAIL divu_100_7: got %h_%h exp 2_14", hi, lo); end
        run_div(F_DIV, 32'hFFFF_FFF9, 32'd2, 10);
        vectors++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin miscompares++; $display("FAIL div_m7_2: got %h_%h exp ffffffff_fffffffd", hi, lo); end
        run_div(F_DIVU, 32'd5, 32'd0, 0);
        run_div(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5);
        vectors++; if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin miscompares++; $display("FAIL div_overflow: got %h_%h exp 0_80000000", hi, lo); end
        run_div(F_DIV, 32'd9, 32'd0, 0);
        run_div(F_DIV, 32'd7, 32'hFFFF_FFFE, TIMEOUT);
    endtask

    // MFLO held through a division: stalled until the first IDLE cycle, then reads the new LO.
    task automatic test_mflo_stall();
        logic [31:0] eh, el, a, b;
        a = 32'hFFFF_FC00; b = 32'd37;
        ref_div(F_DIV, a, b, eh, el);
        @(negedge clk);
        op_valid = 1'b1; op_funct = F_DIV; op_a = a; op_b = b;
        @(negedge clk);
        op_funct = 6'd0;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL unrecognised_stall: got %b exp 0", stall); end
        op_funct = F_MFLO;
        #1;
        vectors++; if ({stall, mf_valid} !== 2'b10) begin miscompares++; $display("FAIL mflo_issue_stall: got %b exp 10", {stall, mf_valid}); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            vectors++; if ({stall, mf_valid} !== 2'b10) begin miscompares++; $display("FAIL mflo_wait_stall: got %b exp 10", {stall, mf_valid}); end
        end
        dv_done = 1'b1; dv_quot = ref_mag(F_DIV, a) / b; dv_rem = ref_mag(F_DIV, a) % b;
        @(negedge clk);
        dv_done = 1'b0;
        #1;
        vectors++; if ({stall, mf_valid, mf_data} !== {2'b01, el}) begin miscompares++; $display("FAIL mflo_after_done: got s=%b v=%b d=%h exp s=0 v=1 d=%h", stall, mf_valid, mf_data, el); end
        @(negedge clk);
        op_valid = 1'b0;
        m_hi = eh; m_lo = el;
        vectors++; if ({hi, lo} !== {m_hi, m_lo}) begin miscompares++; $display("FAIL mflo_hilo: got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        op_valid = 1'b1; op_funct = F_DIVU; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            vectors++; if ({err, busy} !== 2'b01) begin miscompares++; $display("FAIL timeout_wait: cycle %0d got %b exp 01", i, {err, busy}); end
        end
        @(negedge clk);
        vectors++; if ({err, busy} !== 2'b10) begin miscompares++; $display("FAIL timeout_err: got %b exp 10", {err, busy}); end
        vectors++; if ({hi, lo} !== {m_hi, m_lo}) begin miscompares++; $display("FAIL timeout_hilo: got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); end
        dv_done = 1'b1; dv_quot = 32'd333; dv_rem = 32'd1;
        @(negedge clk);
        dv_done = 1'b0;
        vectors++; if ({err, busy} !== 2'b00) begin miscompares++; $display("FAIL timeout_err_pulse: got %b exp 00", {err, busy}); end
        @(negedge clk);
        vectors++; if ({hi, lo} !== {m_hi, m_lo}) begin miscompares++; $display("FAIL idle_done_ignored: got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op_valid = 1'b1; op_funct = F_DIVU; op_a = 32'd77; op_b = 32'd5;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        dv_done = 1'b1; dv_quot = 32'd15; dv_rem = 32'd2;
        @(negedge clk);
        dv_done = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        vectors++; if ({busy, hi, lo} !== {1'b0, 64'd0}) begin miscompares++; $display("FAIL reset_mid: got b=%b %h_%h exp b=0 0_0", busy, hi, lo); end
        do_mt(F_MTHI, 32'h0000_1234);
    endtask

    task automatic test_back_to_back();
        int sel;
        logic [31:0] a, b;
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 5);
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300)));
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
            case (sel)
                0: run_div(F_DIV, a, b, $urandom_range(1, 40));
                1: run_div(F_DIVU, a, b, $urandom_range(1, 40));
                2: do_mt(F_MTHI, a);
                3: do_mt(F_MTLO, a);
                4: do_mf(F_MFHI);
                default: do_mf(F_MFLO);
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_spec_cases();
        do_mf(F_MFHI);
        do_mf(F_MFLO);
        test_mflo_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
